syn_fifo_packer: RTL
====================

SYN_FIFO_PACKER -- requirements
Module: syn_fifo_packer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of one FIFO entry.
REQ-002 The block SHALL have parameter PACK_RATIO, default 4, giving the FIFO entries per output word (power of two, >=2).
REQ-003 Port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 Port fifo_empty_i  input  1  upstream synchronous FIFO empty flag.
REQ-006 Port fifo_rd_o  output  1  read enable to the FIFO, one entry per cycle asserted.
REQ-007 Port fifo_data_i  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_o.
REQ-008 Port flush_i  input  1  single-cycle request to emit the partial word.
REQ-009 Port m_valid_o  output  1  packed word available.
REQ-010 Port m_ready_i  input  1  downstream accepts the word.
REQ-011 Port m_data_o  output  DATA_WIDTH*PACK_RATIO  packed word, entry k in lane k (lane 0 = LSBs).
REQ-012 Port m_strb_o  output  PACK_RATIO  lane-valid mask.
REQ-013 Port m_last_o  output  1  word was terminated by a flush.
REQ-014 Port busy_o  output  1  high when not in IDLE with lane count 0 and no read in flight.

Function
REQ-015 The block SHALL implement states IDLE, FILL, HOLD, plus a lane counter cnt (0..PACK_RATIO), an in-flight flag and a flush-pending flag.
REQ-016 fifo_rd_o SHALL equal: !fifo_empty_i && state!=HOLD && !flush_pend && (cnt + inflight) < PACK_RATIO.
REQ-017 fifo_rd_o SHALL never be asserted while fifo_empty_i is high.
REQ-018 An entry read in cycle n SHALL be captured into lane cnt at the edge ending cycle n+1, and cnt SHALL increment.
REQ-019 IDLE->FILL on the first fifo_rd_o; FILL->HOLD when cnt reaches PACK_RATIO.
REQ-020 m_valid_o SHALL rise in cycle n+2, where n is the cycle of the last read; latency per full word is therefore PACK_RATIO+1 cycles from the first read.
REQ-021 In HOLD, m_valid_o, m_data_o, m_strb_o and m_last_o SHALL stay stable until a cycle with m_ready_i=1.
REQ-022 On acceptance: HOLD->IDLE, cnt=0, m_valid_o low next cycle, and reads may resume in that next cycle.
REQ-023 m_ready_i SHALL be ignored while m_valid_o is low.
REQ-024 A full word SHALL have m_strb_o all ones and m_last_o=0.
REQ-025 flush_i outside HOLD SHALL set flush_pend, which blocks new reads; the block SHALL then wait for any in-flight entry to be captured.
REQ-026 After that capture, if cnt>0, the block SHALL enter HOLD with these outputs:
- m_strb_o = lower cnt bits set;
- unused lanes zero;
- m_last_o=1.
REQ-027 After that capture, if cnt=0, the block SHALL clear flush_pend, emit no word and return to IDLE.
REQ-028 flush_i arriving in the same cycle the last lane is captured SHALL yield a full word with m_last_o=1.
REQ-029 flush_i during HOLD SHALL be latched; after acceptance the block sees cnt=0 and SHALL clear it with no output.
REQ-030 The same entry SHALL never be captured twice.
REQ-031 Entries SHALL never be lost except on reset.

Reset
REQ-032 While rst_i is high, the block SHALL force these values asynchronously:
- state = IDLE;
- cnt, inflight, flush_pend = 0;
- fifo_rd_o, m_valid_o, m_last_o, busy_o = 0;
- m_data_o, m_strb_o = 0.
REQ-033 Reset mid-fill or mid-HOLD SHALL discard the partial/held word and any in-flight entry; the first word after reset SHALL contain only post-reset entries.

Verification
REQ-034 Streaming: FIFO holds 0x11..0x18, m_ready_i=1 -> words 0x14131211 then 0x18171615, strb 0xF, last 0, exactly 8 fifo_rd_o pulses.
REQ-035 Backpressure: hold m_ready_i low 5 cycles with word valid -> m_data_o stable, fifo_rd_o low throughout; word accepted once on release.
REQ-036 Partial flush: 0xA1,0xA2,0xA3 then empty, pulse flush_i -> 0x00A3A2A1, strb 0x7, last 1.
REQ-037 Empty flush: flush_i with cnt=0 and FIFO empty -> no m_valid_o, busy_o returns low within 2 cycles.
REQ-038 Bursty source: fifo_empty_i toggling every other cycle with 0x01..0x04 -> fifo_rd_o never high while empty, single word 0x04030201.
REQ-039 Reset mid-fill: 2 entries captured, pulse rst_i, then 0x31..0x34 -> first output 0x34333231, strb 0xF.

Source files
------------

// File: rtl/syn_fifo_packer.sv
// Packs PACK_RATIO consecutive entries from a synchronous FIFO into one wide
// word with lane strobes, holding it until the downstream side accepts it.
module syn_fifo_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             fifo_empty_i,
    output logic                             fifo_rd_o,
    input  logic [DATA_WIDTH-1:0]            fifo_data_i,
    input  logic                             flush_i,
    output logic                             m_valid_o,
    input  logic                             m_ready_i,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data_o,
    output logic [PACK_RATIO-1:0]            m_strb_o,
    output logic                             m_last_o,
    output logic                             busy_o
);

    localparam int CW = $clog2(PACK_RATIO);
    localparam logic [CW:0] FULL      = (CW+1)'(PACK_RATIO);
    localparam logic [CW:0] LAST_LANE = (CW+1)'(PACK_RATIO - 1);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t                             state, state_nxt;
    logic [CW:0]                        cnt;
    logic [CW:0]                        cnt_sum;
    logic                               inflight;
    logic                               flush_pend;
    logic [DATA_WIDTH*PACK_RATIO-1:0]   data;
    logic [PACK_RATIO-1:0]              strb;
    logic                               last;
    logic                               rd;
    logic                               capture_last;
    logic                               flush_close;
    logic                               accept;

    // Shared decision terms used by both the FSM and the datapath
    always_comb begin
        cnt_sum      = cnt + {{CW{1'b0}}, inflight};
        rd           = !rst_i && !fifo_empty_i && (state != HOLD) && !flush_pend
                       && (cnt_sum < FULL);
        capture_last = (state != HOLD) && inflight && (cnt == LAST_LANE);
        flush_close  = (state != HOLD) && flush_pend && !inflight;
        accept       = (state == HOLD) && m_ready_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd) state_nxt = FILL;
            end
            FILL: begin
                if (capture_last)     state_nxt = HOLD;
                else if (flush_close) state_nxt = (cnt != '0) ? HOLD : IDLE;
            end
            HOLD: begin
                if (m_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_o = rd;
        m_valid_o = (state == HOLD);
        m_data_o  = data;
        m_strb_o  = strb;
        m_last_o  = last;
        busy_o    = !((state == IDLE) && (cnt == '0) && !inflight);
    end

    // A flush seen during the final capture is folded into that word, so
    // flush_pend is cleared there rather than producing a second empty flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt        <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            data       <= '0;
            strb       <= '0;
            last       <= 1'b0;
        end else begin
            inflight <= rd;
            if (accept) begin
                cnt        <= '0;
                data       <= '0;
                strb       <= '0;
                last       <= 1'b0;
                flush_pend <= flush_pend | flush_i;
            end else if (state != HOLD) begin
                if (inflight) begin
                    for (int unsigned k = 0; k < PACK_RATIO; k++) begin
                        if (cnt == (CW+1)'(k))
                            data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_data_i;
                    end
                    cnt <= cnt + 1'b1;
                end
                if (capture_last) begin
                    strb       <= '1;
                    last       <= flush_pend | flush_i;
                    flush_pend <= 1'b0;
                end else if (flush_close) begin
                    for (int unsigned k = 0; k < PACK_RATIO; k++)
                        strb[k] <= ((CW+1)'(k) < cnt);
                    last       <= (cnt != '0);
                    flush_pend <= 1'b0;
                end else begin
                    flush_pend <= flush_pend | flush_i;
                end
            end else begin
                flush_pend <= flush_pend | flush_i;
            end
        end
    end

endmodule
